// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential multiplier controller.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } mult_state_t;

endpackage

// File: rtl/mult_result_reg.sv
// Product hold register: captures the finished product and keeps it until the consumer takes it.
module mult_result_reg
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 out_valid
);

    // Capture sets out_valid; a completed handshake clears it while result is left as-is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            result    <= product;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_controller.sv
// Handshake and strobe sequencer for the shift-add multiplier datapath, one multiplier bit per cycle.
module mult_controller
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_multiplier,
    input  logic [WIDTH-1:0]     in_multiplicand,
    output logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     multiplicand,
    input  logic                 mult_lsb,
    input  logic                 count_check,
    input  logic [2*WIDTH-1:0]   product,
    output logic                 load_words,
    output logic                 add_shift,
    output logic                 shift,
    output logic                 ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int unsigned STEP_W = $clog2(WIDTH) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    mult_state_t        state, state_nxt;
    logic [STEP_W-1:0]  step, step_nxt;
    logic               err_nxt;
    logic [WIDTH-1:0]   multiplier_nxt, multiplicand_nxt;
    logic               capture_c;
    logic               last_step_c;

    assign last_step_c = (step == LAST_STEP);

    // State, step counter, operand and error registers; Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            step         <= '0;
            err          <= 1'b0;
            multiplier   <= '0;
            multiplicand <= '0;
            in_ready     <= 1'b1;
            load_words   <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state        <= state_nxt;
            step         <= step_nxt;
            err          <= err_nxt;
            multiplier   <= multiplier_nxt;
            multiplicand <= multiplicand_nxt;
            in_ready     <= (state_nxt == IDLE);
            load_words   <= (state_nxt == LOAD);
            ready        <= (state_nxt == DONE);
        end
    end

    // Next-state logic; add_shift/shift follow the live multiplier bit so they stay combinational.
    always_comb begin
        state_nxt        = state;
        step_nxt         = step;
        err_nxt          = err;
        multiplier_nxt   = multiplier;
        multiplicand_nxt = multiplicand;
        capture_c        = 1'b0;
        add_shift        = 1'b0;
        shift            = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    multiplier_nxt   = in_multiplier;
                    multiplicand_nxt = in_multiplicand;
                    err_nxt          = 1'b0;
                    step_nxt         = '0;
                    state_nxt        = LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                add_shift = mult_lsb;
                shift     = !mult_lsb;
                step_nxt  = step + STEP_W'(1);
                // Datapath terminal count must agree with our own step count on every RUN cycle.
                if (count_check != last_step_c) begin
                    err_nxt = 1'b1;
                end
                if (last_step_c) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                capture_c = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    mult_result_reg #(
        .WIDTH (WIDTH)
    ) u_result_reg (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture_c),
        .product   (product),
        .out_ready (out_ready),
        .result    (result),
        .out_valid (out_valid)
    );

endmodule
